// File: rtl/sel_dec_pkg.sv
// Shared types and defaults for the pipelined one-hot select decoder.
// Holds the skid-buffer occupancy enum, the default geometry and a ceil-log2 helper.
package sel_dec_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int DEF_SEL_W  = 4;
  localparam int DEF_N_OUT  = 16;
  localparam int DEF_NUM_CH = 2;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sel_onehot_dec.sv
// Combinational single-channel decoder: index plus enable to an N_OUT-bit one-hot word.
// Indices at or beyond N_OUT produce an all-zero word and flag range_err_o.
module sel_onehot_dec #(
  parameter int SEL_W = 4,
  parameter int N_OUT = 16
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N_OUT-1:0] onehot_o,
  output logic             range_err_o
);

  // One extra bit so N_OUT == 2**SEL_W is representable.
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_bit
    assign onehot_o[gi] = en_i & (sel_i == SEL_W'(gi));
  end

  assign range_err_o = en_i & ({1'b0, sel_i} >= N_OUT_L);

endmodule

// File: rtl/sel_decoder_pipe.sv
// Multi-channel registered one-hot select decoder with a valid/ready 2-entry skid buffer.
// Optional SEL_COLLIDE_CHECK_EN adds a per-transaction same-index collision flag.
module sel_decoder_pipe
  import sel_dec_pkg::*;
#(
  parameter int SEL_W  = DEF_SEL_W,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*SEL_W-1:0] sel_in,
  input  logic [NUM_CH-1:0]       en_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*N_OUT-1:0] dec_out,
  output logic [NUM_CH-1:0]       range_err,
  output logic                    collide
);

  localparam int IDX_W = clog2(N_OUT);
  localparam int ENT_W = NUM_CH * N_OUT + NUM_CH + 1;

  if (N_OUT < 2 || IDX_W > SEL_W) begin : g_bad_params
    $error("sel_decoder_pipe: N_OUT must satisfy 2 <= N_OUT <= 2**SEL_W");
  end

  logic [NUM_CH*N_OUT-1:0] dec_c;
  logic [NUM_CH-1:0]       err_c;
  logic                    col_c;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sel_onehot_dec #(
      .SEL_W (SEL_W),
      .N_OUT (N_OUT)
    ) u_dec (
      .sel_i       (sel_in[gi*SEL_W +: SEL_W]),
      .en_i        (en_in[gi]),
      .onehot_o    (dec_c[gi*N_OUT +: N_OUT]),
      .range_err_o (err_c[gi])
    );
  end

`ifdef SEL_COLLIDE_CHECK_EN
  // An enabled channel without range_err is exactly "sel < N_OUT".
  always_comb begin
    col_c = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int d = c + 1; d < NUM_CH; d++) begin
        if (en_in[c] && en_in[d] && !err_c[c] &&
            (sel_in[c*SEL_W +: SEL_W] == sel_in[d*SEL_W +: SEL_W])) begin
          col_c = 1'b1;
        end
      end
    end
  end
`else
  assign col_c = 1'b0;
`endif

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] out_q, out_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  state_e           state_q, state_d;
  logic             take_in, give_out;

  assign in_ent   = {col_c, err_c, dec_c};
  assign in_ready = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign take_in  = in_valid & in_ready;
  assign give_out = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (take_in) begin
          state_d = ONE;
          out_d   = in_ent;
        end
      end
      ONE: begin
        if (take_in && give_out) begin
          out_d = in_ent;
        end else if (take_in) begin
          state_d = TWO;
          skid_d  = in_ent;
        end else if (give_out) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (give_out) begin
          state_d = ONE;
          out_d   = skid_q;
          skid_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign {collide, range_err, dec_out} = out_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot_chk
    always_comb assert ($onehot0(out_q[gi*N_OUT +: N_OUT]));
  end

endmodule

// File: tb/tb_sel_decoder_pipe.sv
// Self-checking bench for sel_decoder_pipe: directed steps plus a random soak against a queue scoreboard.
// A second instance with N_OUT=12 exercises the out-of-range path.
module tb_sel_decoder_pipe;

  localparam int SEL_W  = 4;
  localparam int N_OUT  = 16;
  localparam int NUM_CH = 2;
  localparam int N12    = 12;

`ifdef SEL_COLLIDE_CHECK_EN
  localparam logic EXP_COL = 1'b1;
`else
  localparam logic EXP_COL = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  logic                    in_valid, in_ready, out_valid, out_ready, collide;
  logic [NUM_CH*SEL_W-1:0] sel_in;
  logic [NUM_CH-1:0]       en_in, range_err;
  logic [NUM_CH*N_OUT-1:0] dec_out;

  logic                    iv12, ir12, ov12, col12;
  logic [NUM_CH*SEL_W-1:0] sel12;
  logic [NUM_CH-1:0]       en12, err12;
  logic [NUM_CH*N12-1:0]   dec12;

  sel_decoder_pipe #(.SEL_W(SEL_W), .N_OUT(N_OUT), .NUM_CH(NUM_CH)) u_dut (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .sel_in(sel_in), .en_in(en_in), .out_valid(out_valid), .out_ready(out_ready),
    .dec_out(dec_out), .range_err(range_err), .collide(collide)
  );

  sel_decoder_pipe #(.SEL_W(SEL_W), .N_OUT(N12), .NUM_CH(NUM_CH)) u_dut12 (
    .clock(clock), .clear(clear), .in_valid(iv12), .in_ready(ir12),
    .sel_in(sel12), .en_in(en12), .out_valid(ov12), .out_ready(1'b1),
    .dec_out(dec12), .range_err(err12), .collide(col12)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  logic [34:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: {collide, range_err[1:0], dec[31:0]}.
  function automatic logic [34:0] model(input logic [7:0] sel, input logic [1:0] en);
    logic [31:0] d;
    logic [1:0]  e;
    logic        col;
    logic [3:0]  s;
    d   = '0;
    e   = '0;
    col = 1'b0;
    for (int c = 0; c < 2; c++) begin
      s = sel[c*4 +: 4];
      if (en[c]) begin
        if (int'(s) < N_OUT) d[c*16 + int'(s)] = 1'b1;
        else e[c] = 1'b1;
      end
    end
`ifdef SEL_COLLIDE_CHECK_EN
    col = en[0] & en[1] & (sel[3:0] == sel[7:4]) & (int'(sel[3:0]) < N_OUT);
`endif
    return {col, e, d};
  endfunction

  always @(negedge clock) begin
    if (!clear) begin
      chk("in_ready_vs_model", 64'(in_ready), 64'(sb_q.size() < 2));
      chk("out_valid_vs_model", 64'(out_valid), 64'(sb_q.size() != 0));
      chk("onehot_ch0", 64'($onehot0(dec_out[15:0])), 64'(1));
      chk("onehot_ch1", 64'($onehot0(dec_out[31:16])), 64'(1));
      if (out_valid && sb_q.size() != 0)
        chk("sb_entry", 64'({collide, range_err, dec_out}), 64'(sb_q[0]));
      if (out_valid && out_ready) begin
        n_txn++;
        $display("txn %0d: dec=%h err=%b col=%b", n_txn, dec_out, range_err, collide);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
      end
      if (in_valid && in_ready) sb_q.push_back(model(sel_in, en_in));
    end
  end

  // Called at posedge+1; holds in_valid until accepted, returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] sel, input logic [1:0] en);
    int k;
    in_valid = 1'b1;
    sel_in   = sel;
    en_in    = en;
    for (k = 0; k < 100; k++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    if (k == 100) chk("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send12(input logic [7:0] sel, input logic [1:0] en,
                        input logic [23:0] exp_dec, input logic [1:0] exp_err);
    chk("r12_in_ready", 64'(ir12), 64'(1));
    iv12  = 1'b1;
    sel12 = sel;
    en12  = en;
    @(posedge clock);
    #1;
    iv12 = 1'b0;
    $display("txn12: sel=%h en=%b dec=%h err=%b", sel, en, dec12, err12);
    chk("r12_valid", 64'(ov12), 64'(1));
    chk("r12_dec", 64'(dec12), 64'(exp_dec));
    chk("r12_err", 64'(err12), 64'(exp_err));
    chk("r12_col", 64'(col12), 64'(0));
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_valid = 1'b0; sel_in = '0; en_in = '0; out_ready = 1'b0;
    iv12 = 1'b0; sel12 = '0; en12 = '0;
    clear = 1'b1;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_dec", 64'(dec_out), 64'(0));
    chk("rst_err", 64'(range_err), 64'(0));
    chk("rst_col", 64'(collide), 64'(0));
    @(posedge clock); #1;
    clear = 1'b0;
    #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clock); #1;

    // Single decode
    out_ready = 1'b1;
    send({4'd3, 4'd10}, 2'b11);
    chk("single_dec", 64'(dec_out), 64'(32'h0008_0400));
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_err", 64'(range_err), 64'(0));
    repeat (2) begin @(posedge clock); #1; end

    // Backpressure: two accepted, third held at source
    out_ready = 1'b0;
    in_valid = 1'b1; sel_in = {4'd0, 4'd1}; en_in = 2'b01;
    @(posedge clock); #1; sel_in = {4'd0, 4'd2};
    @(posedge clock); #1; sel_in = {4'd0, 4'd3};
    @(negedge clock); chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_hold", 64'(dec_out[15:0]), 64'(16'h0002));
    chk("bp_still_full", 64'(in_ready), 64'(0));
    @(posedge clock); #1; out_ready = 1'b1;
    @(negedge clock); chk("bp_out0", 64'(dec_out[15:0]), 64'(16'h0002));
    @(posedge clock); #1;
    @(negedge clock); chk("bp_out1", 64'(dec_out[15:0]), 64'(16'h0004));
    @(posedge clock); #1; in_valid = 1'b0;
    @(negedge clock); chk("bp_out2", 64'(dec_out[15:0]), 64'(16'h0008));
    @(posedge clock); #1;
    @(negedge clock); chk("bp_drained", 64'(out_valid), 64'(0));
    @(posedge clock); #1;

    // Asynchronous clear while full
    out_ready = 1'b0;
    in_valid = 1'b1; sel_in = {4'd0, 4'd1}; en_in = 2'b01;
    @(posedge clock); #1; sel_in = {4'd0, 4'd2};
    @(posedge clock); #1; in_valid = 1'b0;
    @(negedge clock); chk("mid_rst_full", 64'(in_ready), 64'(0));
    #2;
    clear = 1'b1;
    sb_q.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_dec", 64'(dec_out), 64'(0));
    chk("mid_rst_err", 64'(range_err), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clock); #1; clear = 1'b0;
    out_ready = 1'b1;
    send({4'd0, 4'd5}, 2'b01);
    chk("mid_rst_next", 64'(dec_out), 64'(32'h0000_0020));
    @(posedge clock); #1;
    chk("mid_rst_no_extra", 64'(out_valid), 64'(0));

    // Collision flag
    send({4'd7, 4'd7}, 2'b11);
    chk("col_dec", 64'(dec_out), 64'(32'h0080_0080));
    chk("col_flag", 64'(collide), 64'(EXP_COL));
    @(posedge clock); #1;
    send({4'd7, 4'd7}, 2'b01);
    chk("col_single_dec", 64'(dec_out), 64'(32'h0000_0080));
    chk("col_single_flag", 64'(collide), 64'(0));
    @(posedge clock); #1;

    // Out-of-range handling on the N_OUT=12 instance
    send12({4'd2, 4'd13}, 2'b01, 24'h000_000, 2'b01);
    send12({4'd2, 4'd13}, 2'b00, 24'h000_000, 2'b00);
    send12({4'd12, 4'd11}, 2'b11, 24'h000_800, 2'b10);

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      sel_in    = 8'($urandom);
      en_in     = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    chk("soak_drained", 64'(out_valid), 64'(0));
    chk("soak_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
